// File: rtl/sine_wg_dds.sv
// Time-multiplexed multi-channel sine DDS: quarter-wave table, per-channel amplitude, optional linear interpolation (SINE_WG_DDS_LINEAR_INTERP_EN).
// Latency: 3 cycles per channel from LOOKUP to m_sg_dv (4 with interpolation).
// Backpressure: sample, channel and valid are held while m_sg_dr=0; ticks arriving mid-burst are dropped and flagged on overrun.
module sine_wg_dds #(
    parameter int NR_CHANNELS    = 4,
    parameter int OUTPUT_WIDTH   = 24,
    parameter int PHASE_WIDTH    = 32,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int AMP_WIDTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           s_tick,
    input  logic                           cfg_wr,
    input  logic [$clog2(NR_CHANNELS)-1:0] cfg_ch,
    input  logic [PHASE_WIDTH-1:0]         cfg_incr,
    input  logic [AMP_WIDTH-1:0]           cfg_amp,
    output logic signed [OUTPUT_WIDTH-1:0] m_sg_d,
    output logic [$clog2(NR_CHANNELS)-1:0] m_sg_ch,
    output logic                           m_sg_dv,
    input  logic                           m_sg_dr,
    output logic                           overrun
);
    localparam int CH_W     = $clog2(NR_CHANNELS);
    localparam int LUT_SIZE = 1 << LUT_ADDR_WIDTH;
    localparam int PROD_W   = OUTPUT_WIDTH + AMP_WIDTH + 1;
    localparam logic [AMP_WIDTH-1:0] AMP_UNITY = AMP_WIDTH'(1) << (AMP_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, INTERP, SCALE, OUTPUT} state_t;

    state_t state, state_nxt;

    logic [PHASE_WIDTH-1:0] phase   [NR_CHANNELS];
    logic [PHASE_WIDTH-1:0] incr    [NR_CHANNELS];
    logic [PHASE_WIDTH-1:0] sh_incr [NR_CHANNELS];
    logic [AMP_WIDTH-1:0]   amp     [NR_CHANNELS];
    logic [AMP_WIDTH-1:0]   sh_amp  [NR_CHANNELS];

    logic [CH_W-1:0]                ch;
    logic                           last_ch;
    logic                           tick_acc;
    logic                           cfg_ok;
    logic signed [OUTPUT_WIDTH-1:0] val_r;

    // Quarter-wave table built at elaboration, endpoints inclusive (sin 0 .. sin pi/2)
    function automatic logic signed [OUTPUT_WIDTH-1:0] lut_entry(input int k);
        real full_scale;
        real angle;
        full_scale = (2.0 ** (OUTPUT_WIDTH - 1)) - 1.0;
        angle      = 3.14159265358979323846 * k / (2.0 ** (LUT_ADDR_WIDTH + 1));
        return OUTPUT_WIDTH'($rtoi(full_scale * $sin(angle) + 0.5));
    endfunction

    logic signed [OUTPUT_WIDTH-1:0] lut [0:LUT_SIZE];

    for (genvar k = 0; k <= LUT_SIZE; k++) begin : g_lut
        localparam logic signed [OUTPUT_WIDTH-1:0] ENTRY = lut_entry(k);
        assign lut[k] = ENTRY;
    end

    if ((1 << CH_W) == NR_CHANNELS) begin : g_cfg_full
        assign cfg_ok = 1'b1;
    end else begin : g_cfg_part
        assign cfg_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(NR_CHANNELS));
    end

    assign last_ch  = (ch == CH_W'(NR_CHANNELS - 1));
    assign tick_acc = (state == IDLE) && s_tick;
    assign m_sg_dv  = (state == OUTPUT);
    assign m_sg_ch  = ch;

    logic [1:0]                     quad;
    logic [LUT_ADDR_WIDTH-1:0]      idx;
    logic [LUT_ADDR_WIDTH:0]        addr_a;
    logic signed [OUTPUT_WIDTH-1:0] lut_a;

    assign quad   = phase[ch][PHASE_WIDTH-1 -: 2];
    assign idx    = phase[ch][PHASE_WIDTH-3 -: LUT_ADDR_WIDTH];
    // Quadrants 1 and 3 walk the table backwards from the peak entry
    assign addr_a = quad[0] ? ((LUT_ADDR_WIDTH + 1)'(LUT_SIZE) - {1'b0, idx}) : {1'b0, idx};
    assign lut_a  = lut[addr_a];

`ifdef SINE_WG_DDS_LINEAR_INTERP_EN
    localparam int FRAC_W = PHASE_WIDTH - 2 - LUT_ADDR_WIDTH;
    localparam int DIFF_W = OUTPUT_WIDTH + FRAC_W + 2;

    logic [LUT_ADDR_WIDTH:0]        addr_b;
    logic signed [OUTPUT_WIDTH-1:0] lut_b, a_r, b_r, y_w;
    logic [FRAC_W-1:0]              frac_r;
    logic                           neg_r;
    logic signed [DIFF_W-1:0]       diff_x, frac_x;

    assign addr_b = quad[0] ? (addr_a - (LUT_ADDR_WIDTH + 1)'(1)) : (addr_a + (LUT_ADDR_WIDTH + 1)'(1));
    assign lut_b  = lut[addr_b];
    assign diff_x = DIFF_W'(b_r) - DIFF_W'(a_r);
    assign frac_x = {{(OUTPUT_WIDTH + 2){1'b0}}, frac_r};
    assign y_w    = a_r + OUTPUT_WIDTH'((diff_x * frac_x) >>> FRAC_W);
`endif

    logic [AMP_WIDTH-1:0]     amp_sat;
    logic signed [PROD_W-1:0] val_x, amp_x;

    assign amp_sat = (sh_amp[ch] > AMP_UNITY) ? AMP_UNITY : sh_amp[ch];
    assign val_x   = PROD_W'(val_r);
    assign amp_x   = {{(OUTPUT_WIDTH + 1){1'b0}}, amp_sat};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_tick) state_nxt = LOOKUP;
`ifdef SINE_WG_DDS_LINEAR_INTERP_EN
            LOOKUP:  state_nxt = INTERP;
`else
            LOOKUP:  state_nxt = SCALE;
`endif
            INTERP:  state_nxt = SCALE;
            SCALE:   state_nxt = OUTPUT;
            OUTPUT:  if (m_sg_dr) state_nxt = last_ch ? IDLE : LOOKUP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch      <= '0;
            val_r   <= '0;
            m_sg_d  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < NR_CHANNELS; i++) begin
                phase[i]   <= '0;
                incr[i]    <= '0;
                sh_incr[i] <= '0;
                amp[i]     <= '0;
                sh_amp[i]  <= '0;
            end
`ifdef SINE_WG_DDS_LINEAR_INTERP_EN
            a_r    <= '0;
            b_r    <= '0;
            frac_r <= '0;
            neg_r  <= 1'b0;
`endif
        end else begin
            overrun <= s_tick && (state != IDLE);
            if (cfg_wr && cfg_ok) begin
                incr[cfg_ch] <= cfg_incr;
                amp[cfg_ch]  <= cfg_amp;
            end
            // Snapshot so mid-burst writes only take effect from the next burst
            if (tick_acc) begin
                for (int i = 0; i < NR_CHANNELS; i++) begin
                    sh_incr[i] <= incr[i];
                    sh_amp[i]  <= amp[i];
                end
            end
            case (state)
                LOOKUP: begin
`ifdef SINE_WG_DDS_LINEAR_INTERP_EN
                    a_r    <= lut_a;
                    b_r    <= lut_b;
                    frac_r <= phase[ch][FRAC_W-1:0];
                    neg_r  <= quad[1];
`else
                    val_r  <= quad[1] ? -lut_a : lut_a;
`endif
                end
                INTERP: begin
`ifdef SINE_WG_DDS_LINEAR_INTERP_EN
                    val_r <= neg_r ? -y_w : y_w;
`endif
                end
                SCALE: begin
                    m_sg_d <= OUTPUT_WIDTH'((val_x * amp_x) >>> (AMP_WIDTH - 1));
                end
                OUTPUT: begin
                    if (m_sg_dr) begin
                        phase[ch] <= phase[ch] + sh_incr[ch];
                        ch        <= last_ch ? '0 : ch + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sine_wg_dds.md
SINE_WG_DDS -- requirements
Module: sine_wg_dds

Interface
REQ-001 SHALL have parameter NR_CHANNELS, default 4: number of time-multiplexed sine channels.
REQ-002 SHALL have parameter OUTPUT_WIDTH, default 24: signed sample width.
REQ-003 SHALL have parameter PHASE_WIDTH, default 32: phase accumulator and increment width.
REQ-004 SHALL have parameter LUT_ADDR_WIDTH, default 8: the quarter-wave table holds 2^LUT_ADDR_WIDTH+1 entries.
REQ-005 SHALL have parameter AMP_WIDTH, default 16: unsigned amplitude width; 2^(AMP_WIDTH-1) is unity.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port s_tick, input, 1: sample-rate strobe that starts one burst.
REQ-009 SHALL have ports cfg_wr (input, 1), cfg_ch (input, clog2(NR_CHANNELS)), cfg_incr (input, PHASE_WIDTH) and cfg_amp (input, AMP_WIDTH): channel configuration write.
REQ-010 SHALL have ports m_sg_d (output, OUTPUT_WIDTH, signed), m_sg_ch (output, clog2(NR_CHANNELS)), m_sg_dv (output, 1) and m_sg_dr (input, 1): sample stream.
REQ-011 SHALL have port overrun, output, 1: one-cycle pulse when a tick is lost.

Function
REQ-012 SHALL keep per channel a phase register, an increment register and an amplitude register.
REQ-013 SHALL latch cfg_incr/cfg_amp into the registers of channel cfg_ch on a clk edge with cfg_wr=1, and SHALL ignore the write when cfg_ch >= NR_CHANNELS.
REQ-014 SHALL copy all increment/amplitude registers into shadow copies on the accepted s_tick; the burst uses only shadow values, so a write mid-burst applies from the next burst.
REQ-015 SHALL use FSM IDLE -> LOOKUP -> INTERP -> SCALE -> OUTPUT -> (next channel LOOKUP | IDLE after channel NR_CHANNELS-1); IDLE -> LOOKUP on s_tick.
REQ-016 SHALL derive quadrant q = phase[PHASE_WIDTH-1:PHASE_WIDTH-2] and idx = the next LUT_ADDR_WIDTH bits.
REQ-017 SHALL read the table at lut[idx] for q=0 and q=2, and at lut[2^LUT_ADDR_WIDTH-idx] for q=1 and q=3, and SHALL negate the value for q=2 and q=3.
REQ-018 SHALL fill the table at elaboration with round((2^(OUTPUT_WIDTH-1)-1)*sin(k*pi/2^(LUT_ADDR_WIDTH+1))), k = 0..2^LUT_ADDR_WIDTH.
REQ-019 SHALL scale as (value*amp) >>> (AMP_WIDTH-1), with amp > 2^(AMP_WIDTH-1) saturated to unity, so the output never exceeds +/-(2^(OUTPUT_WIDTH-1)-1).
REQ-020 SHALL in OUTPUT assert m_sg_dv with m_sg_ch = channel, hold m_sg_d/m_sg_ch stable while m_sg_dr=0, and transfer on the edge with m_sg_dv && m_sg_dr.
REQ-021 SHALL after a transfer deassert m_sg_dv in the next cycle unless the next channel is ready, and SHALL add the shadow increment to the channel phase modulo 2^PHASE_WIDTH.
REQ-022 SHALL compute each sample from the phase before its increment; the first sample after reset is sin(0)=0.
REQ-023 SHALL ignore s_tick outside IDLE and pulse overrun for exactly one cycle; a tick coinciding with the final transfer also counts as overrun.
REQ-024 SHALL take at most 4 cycles from entering LOOKUP to m_sg_dv=1 per channel with m_sg_dr held high.

Reset
REQ-025 SHALL with rst_n=0 at a clk edge clear all phases, increments, amplitudes and shadows, and set FSM=IDLE, m_sg_dv=0, m_sg_d=0, m_sg_ch=0, overrun=0.
REQ-026 SHALL on reset mid-burst abandon the burst without completing the pending transfer; the next s_tick starts at channel 0.

Configuration
REQ-027 SHALL with macro SINE_WG_DDS_LINEAR_INTERP_EN defined add the second entry (index +1 in table direction) and interpolate with the PHASE_WIDTH-2-LUT_ADDR_WIDTH fractional bits: y = a + ((b-a)*frac >> fracbits).
REQ-028 SHALL with SINE_WG_DDS_LINEAR_INTERP_EN undefined bypass INTERP (truncated lookup, FSM skips INTERP), reducing latency by one cycle.

Verification
REQ-029 SHALL cover: incr=0, amp=0x8000, 3 ticks -> every sample 0 on all channels.
REQ-030 SHALL cover: ch0 incr=0x40000000, amp=0x8000 -> ch0 samples 0, 8388607, 0, -8388607 repeating.
REQ-031 SHALL cover: ch1 amp=0x4000 with the REQ-030 increment -> peak +/-4194303 (+/-1 LSB); amp=0xFFFF -> clipped at +/-8388607.
REQ-032 SHALL cover: m_sg_dr low for 50 cycles during OUTPUT -> m_sg_dv stays 1 and m_sg_d/m_sg_ch remain unchanged, no sample is lost.
REQ-033 SHALL cover: s_tick twice, 3 cycles apart -> overrun=1 for one cycle and exactly NR_CHANNELS samples are output.
REQ-034 SHALL cover: rst_n low during channel 2 -> m_sg_dv=0 in the next cycle; the next burst yields sample 0 on channel 0.
